// File: rtl/wave_replay.sv
// Waveform playback driver: replays (delta-time, value) records from a small FIFO
// onto sig_out at their recorded cycle offsets, flagging any late application.
module wave_replay #(
  parameter int DATA_W = 8,
  parameter int DT_W   = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [DT_W-1:0]   rec_dt,
  input  logic [DATA_W-1:0] rec_val,
  input  logic              rec_last,
  output logic [DATA_W-1:0] sig_out,
  output logic              sig_upd,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = DT_W + DATA_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [REC_W-1:0]    fifo_mem [DEPTH];
  logic [AW:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [DT_W-1:0]     elapsed_reg, elapsed_next;
  logic [DATA_W-1:0]   sig_out_reg, sig_out_next;
  logic                sig_upd_reg, sig_upd_next;
  logic                underrun_reg, underrun_next;

  logic                fifo_empty, fifo_full, push;
  logic [DT_W-1:0]     head_dt, tgt_m1;
  logic [DATA_W-1:0]   head_val;
  logic                head_last;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rec_ready  = !rst && !fifo_full && (state_reg != DONE);
  assign push       = rec_valid && rec_ready;

  assign {head_dt, head_val, head_last} = fifo_mem[rd_ptr_reg[AW-1:0]];
  // A dt of zero is treated as one cycle, so its threshold is also zero.
  assign tgt_m1 = (head_dt == '0) ? '0 : head_dt - DT_W'(1);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= {rec_dt, rec_val, rec_last};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      elapsed_reg  <= '0;
      sig_out_reg  <= '0;
      sig_upd_reg  <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= push ? wr_ptr_reg + (AW+1)'(1) : wr_ptr_reg;
      rd_ptr_reg   <= rd_ptr_next;
      elapsed_reg  <= elapsed_next;
      sig_out_reg  <= sig_out_next;
      sig_upd_reg  <= sig_upd_next;
      underrun_reg <= underrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rd_ptr_next   = rd_ptr_reg;
    elapsed_next  = elapsed_reg;
    sig_out_next  = sig_out_reg;
    sig_upd_next  = 1'b0;
    underrun_next = underrun_reg;
    case (state_reg)
      IDLE: begin
        elapsed_next = '0;
        if (enable && !fifo_empty) begin
          state_next    = RUN;
          underrun_next = 1'b0;
        end
      end
      RUN: begin
        if (enable) begin
          if (!fifo_empty && elapsed_reg >= tgt_m1) begin
            sig_out_next = head_val;
            sig_upd_next = 1'b1;
            rd_ptr_next  = rd_ptr_reg + (AW+1)'(1);
            elapsed_next = '0;
            if (elapsed_reg > tgt_m1) underrun_next = 1'b1;
            if (head_last) state_next = DONE;
          end else if (elapsed_reg != '1) begin
            elapsed_next = elapsed_reg + DT_W'(1);
          end
        end
      end
      DONE: begin
        // Leaving DONE discards anything left over from the finished stream.
        if (!enable) begin
          state_next  = IDLE;
          rd_ptr_next = wr_ptr_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sig_out  = sig_out_reg;
  assign sig_upd  = sig_upd_reg;
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_wave_replay.sv
// Self-checking bench for wave_replay: directed scenarios plus randomized streams
// checked every cycle against a queue-based model of record applications.
module tb_wave_replay;
  localparam int DATA_W = 8;
  localparam int DT_W   = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst, enable, rec_valid, rec_ready, rec_last;
  logic [DT_W-1:0]   rec_dt;
  logic [DATA_W-1:0] rec_val, sig_out;
  logic              sig_upd, busy, done, underrun;

  always #5 clk = ~clk;

  wave_replay #(.DATA_W(DATA_W), .DT_W(DT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_dt(rec_dt), .rec_val(rec_val), .rec_last(rec_last),
    .sig_out(sig_out), .sig_upd(sig_upd), .busy(busy), .done(done),
    .underrun(underrun)
  );

  typedef struct {int dt; int val; bit last;} rec_t;

  // Model: queued records, mode (0 idle, 1 playing, 2 finished),
  // edges since the previous application (unbounded), and output flags.
  rec_t q[$];
  int   m_mode, m_since, m_sig;
  bit   m_upd, m_und;
  int   checks = 0;
  int   errors = 0;
  bit   pushed;

  task automatic tick(input bit en, input bit v, input int dt, input int val, input bit last);
    bit   exp_ready;
    int   tgt;
    rec_t r;
    enable = en; rec_valid = v; rec_dt = DT_W'(dt); rec_val = DATA_W'(val); rec_last = last;
    #1;
    exp_ready = (q.size() < DEPTH) && (m_mode != 2);
    checks++;
    if (rec_ready !== exp_ready) begin
      errors++;
      $display("FAIL rec_ready t=%0t got %b want %b", $time, rec_ready, exp_ready);
    end
    pushed = v && exp_ready;
    m_upd  = 1'b0;
    tgt    = 1;
    case (m_mode)
      0: if (en && q.size() > 0) begin m_mode = 1; m_since = 0; m_und = 1'b0; end
      1: if (en) begin
        if (q.size() > 0) tgt = (q[0].dt == 0) ? 1 : q[0].dt;
        // The head is applied once tgt edges have passed since the last application.
        if (q.size() > 0 && m_since + 1 >= tgt) begin
          m_sig = q[0].val;
          m_upd = 1'b1;
          if (m_since + 1 > tgt) m_und = 1'b1;
          if (q[0].last) m_mode = 2;
          void'(q.pop_front());
          m_since = 0;
        end else begin
          m_since++;
        end
      end
      default: if (!en) begin m_mode = 0; q.delete(); end
    endcase
    if (pushed) begin r.dt = dt; r.val = val; r.last = last; q.push_back(r); end
    @(posedge clk); #1;
    checks++;
    if (sig_out !== DATA_W'(m_sig)) begin errors++; $display("FAIL sig_out t=%0t got %h want %h", $time, sig_out, DATA_W'(m_sig)); end
    checks++;
    if (sig_upd !== m_upd) begin errors++; $display("FAIL sig_upd t=%0t got %b want %b", $time, sig_upd, m_upd); end
    checks++;
    if (busy !== (m_mode == 1)) begin errors++; $display("FAIL busy t=%0t got %b want %b", $time, busy, m_mode == 1); end
    checks++;
    if (done !== (m_mode == 2)) begin errors++; $display("FAIL done t=%0t got %b want %b", $time, done, m_mode == 2); end
    checks++;
    if (underrun !== m_und) begin errors++; $display("FAIL underrun t=%0t got %b want %b", $time, underrun, m_und); end
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 1'b0; rec_valid = 1'b0; rec_dt = '0; rec_val = '0; rec_last = 1'b0;
    #1;
    checks++;
    if (rec_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rec_ready); end
    @(posedge clk); #1;
    q.delete(); m_mode = 0; m_since = 0; m_sig = 0; m_upd = 1'b0; m_und = 1'b0;
    checks++;
    if ({sig_out, sig_upd, busy, done, underrun} !== '0) begin
      errors++;
      $display("FAIL reset_state got out=%h upd=%b busy=%b done=%b und=%b want all 0",
               sig_out, sig_upd, busy, done, underrun);
    end
    rst = 1'b0;
  endtask

  task automatic to_idle();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_basic();
    tick(0, 1, 3, 'h0F, 0);
    tick(0, 1, 2, 'h0A, 1);
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (sig_upd !== (i == 3 || i == 5)) begin errors++; $display("FAIL basic_upd E0+%0d got %b", i, sig_upd); end
      if (i == 3) begin
        checks++;
        if (sig_out !== 8'h0F) begin errors++; $display("FAIL basic_first got %h want 0f", sig_out); end
      end
    end
    checks++;
    if (sig_out !== 8'h0A || done !== 1'b1 || underrun !== 1'b0) begin
      errors++; $display("FAIL basic_end got out=%h done=%b und=%b want 0a 1 0", sig_out, done, underrun);
    end
    to_idle();
  endtask

  task automatic test_dt0();
    logic [7:0] exp_v [3];
    exp_v = '{8'h11, 8'h22, 8'h33};
    tick(0, 1, 0, 'h11, 0);
    tick(0, 1, 0, 'h22, 0);
    tick(0, 1, 1, 'h33, 1);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (sig_upd !== 1'b1 || sig_out !== exp_v[i]) begin
        errors++; $display("FAIL dt0 E0+%0d got upd=%b out=%h want 1 %h", i + 1, sig_upd, sig_out, exp_v[i]);
      end
    end
    to_idle();
  endtask

  task automatic test_underrun();
    tick(0, 1, 1, 'h55, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (sig_out !== 8'h55) begin errors++; $display("FAIL under_first got %h want 55", sig_out); end
    repeat (5) tick(1, 0, 0, 0, 0);
    tick(1, 1, 2, 'h66, 1);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (sig_upd !== 1'b1 || sig_out !== 8'h66 || underrun !== 1'b1) begin
      errors++; $display("FAIL under_late got upd=%b out=%h und=%b want 1 66 1", sig_upd, sig_out, underrun);
    end
    tick(1, 0, 0, 0, 0);
    to_idle();
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL under_sticky got %b want 1", underrun); end
  endtask

  task automatic test_full();
    int n_push = 0;
    int n_upd  = 0;
    int cyc    = 0;
    int first  = -1;
    for (int i = 0; i < 4; i++) tick(0, 1, 10, 'h40 + i, 0);
    checks++;
    if (rec_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", rec_ready); end
    tick(1, 0, 0, 0, 0);
    while (m_mode != 2 && cyc < 80) begin
      tick(1, n_push == 0, 10, 'h44, 1);
      cyc++;
      if (pushed) n_push++;
      if (sig_upd === 1'b1) begin
        n_upd++;
        if (first < 0) begin
          first = cyc;
          checks++;
          if (rec_ready !== 1'b1) begin errors++; $display("FAIL full_reopen got %b want 1", rec_ready); end
        end
      end
    end
    checks++;
    if (first != 10 || n_upd != 5 || done !== 1'b1) begin
      errors++; $display("FAIL full_stream got first=E0+%0d applies=%0d done=%b want E0+10 5 1", first, n_upd, done);
    end
    to_idle();
  endtask

  task automatic test_pause();
    tick(0, 1, 5, 'h5A, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    repeat (7) tick(0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0, 0, 0, 0);
      checks++;
      if (sig_upd !== (i == 3)) begin errors++; $display("FAIL pause_upd enabled edge %0d got %b", i, sig_upd); end
    end
    checks++;
    if (sig_out !== 8'h5A || underrun !== 1'b0) begin
      errors++; $display("FAIL pause_end got out=%h und=%b want 5a 0", sig_out, underrun);
    end
    to_idle();
  endtask

  task automatic test_reset_mid();
    tick(0, 1, 1, 'hA5, 0);
    tick(0, 1, 50, 'h01, 0);
    tick(0, 1, 50, 'h02, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (sig_out !== 8'hA5 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre got out=%h busy=%b want a5 1", sig_out, busy); end
    apply_reset();
    tick(1, 0, 0, 0, 0);
    checks++;
    if (busy !== 1'b0 || rec_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_flush got busy=%b ready=%b want 0 1", busy, rec_ready);
    end
    to_idle();
  endtask

  task automatic test_saturate();
    tick(0, 1, 1, 'h77, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    repeat (300) tick(1, 0, 0, 0, 0);
    tick(1, 1, 255, 'h99, 1);
    tick(1, 0, 0, 0, 0);
    checks++;
    if (sig_upd !== 1'b1 || sig_out !== 8'h99 || underrun !== 1'b1) begin
      errors++; $display("FAIL saturate got upd=%b out=%h und=%b want 1 99 1", sig_upd, sig_out, underrun);
    end
    to_idle();
  endtask

  task automatic test_random();
    int n, idx, guard;
    bit en_r, v_r;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      idx = 0;
      guard = 0;
      while ((idx < n || m_mode != 2) && guard < 600) begin
        en_r = ($urandom_range(0, 4) != 0);
        v_r  = (idx < n) && ($urandom_range(0, 2) != 0);
        tick(en_r, v_r, $urandom_range(0, 4), $urandom_range(0, 255), idx == n - 1);
        if (pushed) idx++;
        guard++;
      end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL random_done round %0d got %b want 1", r, done); end
      to_idle();
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rec_valid = 1'b0; rec_dt = '0; rec_val = '0; rec_last = 1'b0;
    test_reset();
    test_basic();
    test_dt0();
    test_underrun();
    test_full();
    test_pause();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_replay.md
# wave_replay

Waveform playback driver: consumes a stream of (delta-time, value) records from a dump reader and drives an 8-bit stimulus signal, applying each value at its recorded cycle offset. It is the replay side of the dump path: signals captured to a waveform file are re-driven into a DUT input such as a `dut_0`/`dut_1`-style register stage. A small record FIFO absorbs reader jitter. A sticky flag reports any record that was applied later than scheduled.

## Interface

- Clocking: one clock; reset is synchronous and active-high.
- `DATA_W`, default 8: width of the replayed value.
- `DT_W`, default 16: width of the delta-time field and of the elapsed counter.
- `DEPTH`, default 4: record FIFO depth; must be a power of 2 and at least 2.

Ports (name, direction, width, meaning):

- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `enable`, in, 1: run/pause playback.
- `rec_valid`, in, 1: input record valid.
- `rec_ready`, out, 1: FIFO can accept a record.
- `rec_dt`, in, DT_W: cycles from the previous application to this one.
- `rec_val`, in, DATA_W: value to drive.
- `rec_last`, in, 1: final record of the stream.
- `sig_out`, out, DATA_W: replayed signal.
- `sig_upd`, out, 1: one-cycle pulse; `sig_out` was loaded on this edge.
- `busy`, out, 1: state is RUN.
- `done`, out, 1: the last record has been applied.
- `underrun`, out, 1: sticky; some record was applied late.

## Operation

- FIFO behaviour:
  - A push occurs when `rec_valid && rec_ready`; the record stores {dt, val, last}.
  - `rec_ready = !rst && !full && state != DONE`. It is combinational.
  - When the FIFO is full, `rec_ready` is 0 even if a pop occurs in the same cycle.
- Elapsed counter: `elapsed` is a DT_W-bit counter that saturates at 2^DT_W−1. `tgt = max(head.dt, 1)`.
- FSM states are IDLE, RUN and DONE.
  - IDLE: `elapsed` is held at 0. On an edge where `enable` is 1 and the FIFO is non-empty, go to RUN and set `elapsed` to 0. No value is applied on this edge; the entry edge counts as the previous application.
  - RUN, `enable` = 0: pause. `elapsed` is frozen and nothing is applied.
  - RUN, `enable` = 1, head valid and `elapsed >= tgt−1` (apply edge):
    - load `sig_out` with `head.val`, pop the FIFO, set `elapsed` to 0 and pulse `sig_upd`;
    - if `elapsed > tgt−1`, set `underrun` (the record was late);
    - if `head.last`, go to DONE.
  - RUN otherwise: increment `elapsed` (saturating). A FIFO that is empty in RUN is not itself an error.
  - DONE: `done` = 1, `sig_out` holds its value, no pushes are accepted. When `enable` = 0, go to IDLE and clear `done`. Any stale FIFO contents are flushed on that transition.
- Flag clearing: `underrun` clears only on reset or on an IDLE→RUN transition.
- Delta-time rules:
  - Consecutive applications are exactly `max(dt,1)` edges apart when records arrive in time. `dt` = 0 behaves as `dt` = 1.
  - `dt` is compared unsigned and at full DT_W width.
  - A late record is applied on the first edge where it is at the head, provided `enable` is 1.

## Timing

- Reset values: `sig_out` = 0, `sig_upd` = 0, `busy` = 0, `done` = 0, `underrun` = 0, FIFO empty, state IDLE.
- Reset mid-playback: everything returns to these values on the next edge and the FIFO contents are discarded.
- `rec_ready` is 0 while `rst` is high.
- FIFO latency: a record pushed on edge k is visible at the head from cycle k+1. At the earliest it can be applied on edge k+1.
- Empty FIFO: a simultaneous push and pop cannot occur, because the pop requires a valid head.
- Output timing:
  - `sig_out` and `sig_upd` change on the apply edge itself.
  - `busy` reflects the registered state.
  - `done` rises on the edge that applies the last record.
- Boundaries:
  - While `elapsed` is saturated, a waiting record with `dt` = 2^DT_W−1 is still applied (its `tgt−1` is reachable).
  - `enable` dropping on what would have been an apply edge defers the application. Because `elapsed` is frozen, no `underrun` results.

## Test plan

- Basic replay:
  - Stimulus: push {3, 0x0F}, {2, 0x0A, last}, then raise `enable`; edge E0 is the IDLE→RUN edge.
  - Required: `sig_out` = 0x0F after E0+3 and 0x0A after E0+5; `sig_upd` pulses on exactly those two edges; `done` = 1 from E0+5; `underrun` = 0.
- dt = 0:
  - Stimulus: records {0, 0x11}, {0, 0x22}, {1, 0x33, last}.
  - Required: values applied on E0+1, E0+2 and E0+3.
- Underrun:
  - Stimulus: record {1, 0x55}, then withhold the second record {2, 0x66, last} until 6 cycles after the first apply.
  - Required: 0x66 is applied one edge after it is pushed, `underrun` = 1 and stays 1 through DONE.
- Full FIFO with a stalled head:
  - Stimulus: push 4 records with `dt` = 10 while `enable` = 0.
  - Required: `rec_ready` = 0 after the 4th push. After `enable` rises, `rec_ready` returns to 1 in the cycle after the first apply. No record is lost or duplicated.
- Pause:
  - Stimulus: a record with `dt` = 5; drop `enable` at `elapsed` = 2 for 7 cycles, then restore it.
  - Required: the apply happens exactly 3 enabled edges later; `underrun` = 0.
- Reset mid-run:
  - Stimulus: assert `rst` for one cycle while in RUN with 2 records queued and `sig_out` = 0xA5.
  - Required: the next edge gives `sig_out` = 0, state IDLE, FIFO empty, `rec_ready` = 1 after `rst` deasserts.
